// File: rtl/link_supervisor.sv
// Link-level supervisor for the coax receive path: sequences CDR/framer reset,
// qualifies lock from per-frame status strobes and keeps saturating link statistics.
module link_supervisor #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FRAMES  = 4,
    parameter int MAX_ERRS     = 8,
    parameter int WDOG_CYCLES  = 4096,
    parameter int HUNT_TIMEOUT = 65536,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             frame_good,
    input  logic             frame_error,
    input  logic             sync_lost,
    input  logic             stat_clear,
    output logic             rx_rst_n,
    output logic             link_up,
    output logic [1:0]       state,
    output logic             link_down_evt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] resync_cnt
);

    localparam int TMR_MAX = (HUNT_TIMEOUT > RST_CYCLES) ? HUNT_TIMEOUT : RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RUN_W   = $clog2(LOCK_FRAMES + 1);
    localparam int ERR_W   = $clog2(MAX_ERRS + 1);
    localparam int WDG_W   = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_HOLD   = 2'd1,
        S_HUNT   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [TMR_W-1:0]   r_timer, w_timer_next;
    logic [RUN_W-1:0]   r_run, w_run_next;
    logic [ERR_W-1:0]   r_err_run, w_err_run_next;
    logic [WDG_W-1:0]   r_wdog, w_wdog_next;
    logic               r_rx_rst_n, r_link_up, r_evt;
    logic               w_resync;
    logic               w_good_clean;
    logic               w_stat_active;
    logic [2:0]         w_inc;
    logic [CNT_W-1:0]   r_cnt [3];

    // A frame only counts as good for state decisions when no error accompanies it.
    assign w_good_clean = frame_good & ~frame_error;

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_run_next     = r_run;
        w_err_run_next = r_err_run;
        w_wdog_next    = r_wdog;
        w_resync       = 1'b0;

        case (r_state)
            S_OFF: begin
                w_state_next = S_HOLD;
                w_timer_next = '0;
            end
            S_HOLD: begin
                if (r_timer == TMR_W'(RST_CYCLES - 1)) begin
                    w_state_next = S_HUNT;
                    w_timer_next = '0;
                    w_run_next   = '0;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            S_HUNT: begin
                w_timer_next = r_timer + TMR_W'(1);
                if (frame_error || sync_lost) begin
                    w_run_next = '0;
                end else if (frame_good) begin
                    w_run_next = r_run + RUN_W'(1);
                end
                if (frame_good && !frame_error && !sync_lost &&
                    r_run == RUN_W'(LOCK_FRAMES - 1)) begin
                    w_state_next   = S_LOCKED;
                    w_err_run_next = '0;
                    w_wdog_next    = '0;
                end else if (r_timer == TMR_W'(HUNT_TIMEOUT - 1)) begin
                    w_state_next = S_HOLD;
                    w_timer_next = '0;
                    w_resync     = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_good_clean) begin
                    w_err_run_next = '0;
                    w_wdog_next    = '0;
                end else begin
                    w_wdog_next = r_wdog + WDG_W'(1);
                end
                if (frame_error) begin
                    w_err_run_next = r_err_run + ERR_W'(1);
                end
                if ((frame_error && r_err_run == ERR_W'(MAX_ERRS - 1)) ||
                    (!w_good_clean && r_wdog == WDG_W'(WDOG_CYCLES - 1))) begin
                    w_state_next = S_HOLD;
                    w_timer_next = '0;
                    w_resync     = 1'b1;
                end
            end
            default: w_state_next = S_OFF;
        endcase

        // Dropping enable overrides every other transition, and never counts as a resync.
        if (!enable) begin
            w_state_next = S_OFF;
            w_timer_next = '0;
            w_resync     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_OFF;
            r_timer    <= '0;
            r_run      <= '0;
            r_err_run  <= '0;
            r_wdog     <= '0;
            r_rx_rst_n <= 1'b0;
            r_link_up  <= 1'b0;
            r_evt      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_run      <= w_run_next;
            r_err_run  <= w_err_run_next;
            r_wdog     <= w_wdog_next;
            r_rx_rst_n <= (w_state_next == S_HUNT) || (w_state_next == S_LOCKED);
            r_link_up  <= (w_state_next == S_LOCKED);
            r_evt      <= (r_state == S_LOCKED) && (w_state_next != S_LOCKED);
        end
    end

    assign w_stat_active = (r_state == S_HUNT) || (r_state == S_LOCKED);
    assign w_inc[0]      = w_stat_active & frame_good;
    assign w_inc[1]      = w_stat_active & frame_error;
    assign w_inc[2]      = w_resync;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (stat_clear) begin
                    r_cnt[gi] <= '0;
                end else if (w_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign state         = r_state;
    assign rx_rst_n      = r_rx_rst_n;
    assign link_up       = r_link_up;
    assign link_down_evt = r_evt;
    assign good_cnt      = r_cnt[0];
    assign err_cnt       = r_cnt[1];
    assign resync_cnt    = r_cnt[2];

endmodule

// File: tb/tb_link_supervisor.sv
// Table-driven bench for link_supervisor: each record idles, drives one strobe cycle,
// and its expected outputs go through a scoreboard queue checked after the next edge.
module tb_link_supervisor;

    localparam int CW = 10;   // narrow counters so saturation is reachable quickly
    localparam int HT = 300;  // short hunt timeout so it can be exercised

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_good = 1'b0;
    logic          frame_error = 1'b0;
    logic          sync_lost = 1'b0;
    logic          stat_clear = 1'b0;
    logic          rx_rst_n;
    logic          link_up;
    logic [1:0]    state;
    logic          link_down_evt;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] resync_cnt;

    link_supervisor #(
        .RST_CYCLES  (16),
        .LOCK_FRAMES (4),
        .MAX_ERRS    (8),
        .WDOG_CYCLES (4096),
        .HUNT_TIMEOUT(HT),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_good   (frame_good),
        .frame_error  (frame_error),
        .sync_lost    (sync_lost),
        .stat_clear   (stat_clear),
        .rx_rst_n     (rx_rst_n),
        .link_up      (link_up),
        .state        (state),
        .link_down_evt(link_down_evt),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt),
        .resync_cnt   (resync_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idle;
        logic          en, g, e, s, c;
        logic [1:0]    st;
        logic          up, rxn, evt;
        logic [CW-1:0] gc, ec, rc;
    } vec_t;

    typedef struct {
        bit   chk;
        int   idx;
        vec_t v;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mkv(int idle, logic en, logic g, logic e, logic s, logic c,
                                 logic [1:0] st, logic evt, int gc, int ec, int rc);
        vec_t v;
        v.idle = idle; v.en = en; v.g = g; v.e = e; v.s = s; v.c = c;
        v.st  = st;
        v.up  = (st == 2'd3);
        v.rxn = (st == 2'd2) || (st == 2'd3);
        v.evt = evt;
        v.gc  = CW'(gc); v.ec = CW'(ec); v.rc = CW'(rc);
        return v;
    endfunction

    task automatic add(int idle, logic en, logic g, logic e, logic s, logic c,
                       logic [1:0] st, logic evt, int gc, int ec, int rc);
        tbl.push_back(mkv(idle, en, g, e, s, c, st, evt, gc, ec, rc));
    endtask

    task automatic compare(string nm, vec_t x);
        n_vec++;
        if (state !== x.st || link_up !== x.up || rx_rst_n !== x.rxn || link_down_evt !== x.evt ||
            good_cnt !== x.gc || err_cnt !== x.ec || resync_cnt !== x.rc) begin
            n_bad++;
            $display("FAIL %s: got st=%0d up=%b rxn=%b evt=%b good=%0d err=%0d resync=%0d, required st=%0d up=%b rxn=%b evt=%b good=%0d err=%0d resync=%0d",
                     nm, state, link_up, rx_rst_n, link_down_evt, good_cnt, err_cnt, resync_cnt,
                     x.st, x.up, x.rxn, x.evt, x.gc, x.ec, x.rc);
        end
    endtask

    task automatic drive(vec_t v, bit chk, int idx);
        sb_t e;
        @(posedge clk);
        #2;
        enable      = v.en;
        frame_good  = v.g;
        frame_error = v.e;
        sync_lost   = v.s;
        stat_clear  = v.c;
        e.chk = chk; e.idx = idx; e.v = v;
        sbq.push_back(e);
    endtask

    // Scoreboard: each driven cycle's expectation is checked just after the edge that consumes it.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) compare($sformatf("vec%0d", e.idx), e.v);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, required completion within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle_v;
        int   wait_cyc;

        // Bring-up, hold length, strobes ignored in HOLD
        add(2,  0, 0,0,0,0, 0, 0, 0,0,0);
        add(0,  1, 0,0,0,0, 1, 0, 0,0,0);
        add(14, 1, 1,1,0,0, 1, 0, 0,0,0);
        add(0,  1, 0,0,0,0, 2, 0, 0,0,0);
        // Four spaced good frames lock the link
        for (int i = 1; i <= 3; i++) add(9, 1, 1,0,0,0, 2, 0, i,0,0);
        add(9,  1, 1,0,0,0, 3, 0, 4,0,0);
        // Seven errors then a good frame stay locked
        for (int i = 1; i <= 7; i++) add(0, 1, 0,1,0,0, 3, 0, 4,i,0);
        add(0,  1, 1,0,0,0, 3, 0, 5,7,0);
        // Eight consecutive errors drop to HOLD with one event pulse
        for (int i = 1; i <= 7; i++) add(0, 1, 0,1,0,0, 3, 0, 5,7+i,0);
        add(0,  1, 0,1,0,0, 1, 1, 5,15,1);
        add(0,  1, 0,0,0,0, 1, 0, 5,15,1);
        add(14, 1, 0,0,0,1, 2, 0, 0,0,0);
        // Hunt with an interrupting error: lock only after a fresh run of four
        for (int i = 1; i <= 3; i++) add(2, 1, 1,0,0,0, 2, 0, i,0,0);
        add(2,  1, 0,1,0,0, 2, 0, 3,1,0);
        for (int i = 4; i <= 6; i++) add(2, 1, 1,0,0,0, 2, 0, i,1,0);
        add(2,  1, 1,0,0,0, 3, 0, 7,1,0);
        // sync_lost tolerated; good+error counts both but does not clear err_run
        add(0,  1, 0,0,1,0, 3, 0, 7,1,0);
        add(0,  1, 1,1,0,0, 3, 0, 8,2,0);
        for (int i = 3; i <= 8; i++) add(0, 1, 0,1,0,0, 3, 0, 8,i,0);
        add(0,  1, 0,1,0,0, 1, 1, 8,9,1);
        add(14, 1, 0,0,0,0, 1, 0, 8,9,1);
        add(0,  1, 0,0,0,0, 2, 0, 8,9,1);
        // Hunt timeout boundary
        add(HT-2, 1, 0,0,0,0, 2, 0, 8,9,1);
        add(0,    1, 0,0,0,0, 1, 0, 8,9,2);
        add(15,   1, 0,0,0,0, 2, 0, 8,9,2);
        for (int i = 9; i <= 11; i++) add(0, 1, 1,0,0,0, 2, 0, i,9,2);
        add(0,  1, 1,0,0,0, 3, 0, 12,9,2);
        // Watchdog boundary
        add(4094, 1, 0,0,0,0, 3, 0, 12,9,2);
        add(0,    1, 0,0,0,0, 1, 1, 12,9,3);
        add(0,    1, 0,0,0,0, 1, 0, 12,9,3);
        add(14,   1, 0,0,0,0, 2, 0, 12,9,3);
        for (int i = 13; i <= 15; i++) add(0, 1, 1,0,0,0, 2, 0, i,9,3);
        add(0,  1, 1,0,0,0, 3, 0, 16,9,3);
        // Enable drop from LOCKED, then full re-hold
        add(0,  0, 0,0,0,0, 0, 1, 16,9,3);
        add(0,  0, 0,0,0,0, 0, 0, 16,9,3);
        add(0,  1, 0,0,0,0, 1, 0, 16,9,3);
        add(14, 1, 0,0,0,0, 1, 0, 16,9,3);
        add(0,  1, 0,0,0,0, 2, 0, 16,9,3);
        for (int i = 17; i <= 19; i++) add(0, 1, 1,0,0,0, 2, 0, i,9,3);
        add(0,  1, 1,0,0,0, 3, 0, 20,9,3);
        // Saturation and clear-beats-increment
        for (int i = 21; i < (1 << CW); i++) add(0, 1, 1,0,0,0, 3, 0, i,9,3);
        for (int i = 0; i < 3; i++) add(0, 1, 1,0,0,0, 3, 0, (1 << CW) - 1,9,3);
        add(0,  1, 1,0,0,1, 3, 0, 0,0,0);
        add(0,  1, 1,0,0,0, 3, 0, 1,0,0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        compare("reset", mkv(0, 0, 0,0,0,0, 0, 0, 0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            idle_v = tbl[i];
            idle_v.g = 1'b0; idle_v.e = 1'b0; idle_v.s = 1'b0; idle_v.c = 1'b0;
            for (int k = 0; k < tbl[i].idle; k++) drive(idle_v, 1'b0, i);
            drive(tbl[i], 1'b1, i);
        end
        idle_v = mkv(0, 1, 0,0,0,0, 3, 0, 1,0,0);
        drive(idle_v, 1'b0, -1);
        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 8) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, required 0", sbq.size());
        end

        // Asynchronous reset mid-operation, then OFF before a new hold
        #1;
        rst_n = 1'b0;
        #1;
        compare("async_reset", mkv(0, 1, 0,0,0,0, 0, 0, 0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare("off_after_release", mkv(0, 1, 0,0,0,0, 0, 0, 0,0,0));
        drive(mkv(0, 1, 0,0,0,0, 1, 0, 0,0,0), 1'b1, 9000);
        drive(mkv(0, 1, 0,0,0,0, 1, 0, 0,0,0), 1'b1, 9001);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
